// File: rtl/tile_store2d_vec.sv
// Tile store: buffers one OUT_H x OUT_W result tile written PIX_PER_CLK lanes per beat, then drains it row-major.
// Optional macro TILE_STORE_STALL_CNT_EN adds stall_cnt, a saturating count of stalled drain cycles.
module tile_store2d_vec #(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 30,
  parameter int OUT_H       = 30,
  parameter int PIX_PER_CLK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*PIX_PER_CLK-1:0] in_pixels,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*PIX_PER_CLK-1:0] out_pixels,
  output logic [PIX_PER_CLK-1:0]        out_keep,
  output logic                          out_last
`ifdef TILE_STORE_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int BPR = (OUT_W + PIX_PER_CLK - 1) / PIX_PER_CLK;
  localparam int XW  = $clog2(BPR * PIX_PER_CLK + 1);
  localparam int YW  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int PW  = DATA_W * PIX_PER_CLK;
  localparam logic [XW-1:0] STEP_X = XW'(PIX_PER_CLK);
  localparam logic [XW-1:0] LIM_X  = XW'(OUT_W);
  localparam logic [YW-1:0] LAST_Y = YW'(OUT_H - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [XW-1:0]       wr_x_r;
  logic [YW-1:0]       wr_y_r;
  logic [XW-1:0]       rd_x_r;
  logic [YW-1:0]       rd_y_r;
  logic                in_fire_s;
  logic                out_fire_s;
  logic                wr_row_end_s;
  logic                wr_last_s;
  logic                rd_row_end_s;
  logic                rd_last_s;
  logic [XW-1:0]       fetch_x_s;
  logic [YW-1:0]       fetch_y_s;
  logic [XW-1:0]       fetch_col_s [PIX_PER_CLK];
  logic [PW-1:0]       fetch_pix_s;
  logic [PIX_PER_CLK-1:0] fetch_keep_s;
  logic                fetch_last_s;
  logic [DATA_W-1:0]   mem_r [OUT_H][OUT_W];
  logic [PW-1:0]       pix_r;
  logic [PIX_PER_CLK-1:0] keep_r;
  logic                last_r;

  assign in_ready     = (state_r == FILL);
  assign out_valid    = (state_r == DRAIN);
  assign out_pixels   = pix_r;
  assign out_keep     = keep_r;
  assign out_last     = last_r;
  assign in_fire_s    = in_valid && (state_r == FILL);
  assign out_fire_s   = out_ready && (state_r == DRAIN);
  assign wr_row_end_s = (wr_x_r + STEP_X) >= LIM_X;
  assign wr_last_s    = wr_row_end_s && (wr_y_r == LAST_Y);
  assign rd_row_end_s = (rd_x_r + STEP_X) >= LIM_X;
  assign rd_last_s    = rd_row_end_s && (rd_y_r == LAST_Y);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FILL: begin
        if (in_fire_s && wr_last_s) state_nx_s = DRAIN;
        else                        state_nx_s = FILL;
      end
      DRAIN: begin
        if (out_fire_s && rd_last_s) state_nx_s = FILL;
        else                         state_nx_s = DRAIN;
      end
      default: state_nx_s = FILL;
    endcase
  end

  // Write and read pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_x_r <= '0;
      wr_y_r <= '0;
      rd_x_r <= '0;
      rd_y_r <= '0;
    end else begin
      if (in_fire_s) begin
        if (wr_last_s) begin
          wr_x_r <= '0;
          wr_y_r <= '0;
        end else if (wr_row_end_s) begin
          wr_x_r <= '0;
          wr_y_r <= wr_y_r + YW'(1);
        end else begin
          wr_x_r <= wr_x_r + STEP_X;
        end
      end
      if (out_fire_s) begin
        if (rd_last_s) begin
          rd_x_r <= '0;
          rd_y_r <= '0;
        end else if (rd_row_end_s) begin
          rd_x_r <= '0;
          rd_y_r <= rd_y_r + YW'(1);
        end else begin
          rd_x_r <= rd_x_r + STEP_X;
        end
      end
    end
  end

  // Address of the beat to present next: the following beat on a drain handshake, else the tile start
  always_comb begin
    fetch_x_s = '0;
    fetch_y_s = '0;
    if (out_fire_s && !rd_last_s) begin
      if (rd_row_end_s) begin
        fetch_x_s = '0;
        fetch_y_s = rd_y_r + YW'(1);
      end else begin
        fetch_x_s = rd_x_r + STEP_X;
        fetch_y_s = rd_y_r;
      end
    end else begin
      fetch_x_s = '0;
      fetch_y_s = '0;
    end
  end

  // Lane gather for the fetched beat; a one-beat tile forwards the beat being written
  always_comb begin
    fetch_pix_s  = '0;
    fetch_keep_s = '0;
    for (int l = 0; l < PIX_PER_CLK; l++) begin
      fetch_col_s[l]  = fetch_x_s + XW'(l);
      fetch_keep_s[l] = (fetch_col_s[l] < LIM_X);
      for (int x = 0; x < OUT_W; x++) begin
        if (fetch_col_s[l] == XW'(x)) fetch_pix_s[l*DATA_W +: DATA_W] = mem_r[fetch_y_s][x];
        else                          fetch_pix_s[l*DATA_W +: DATA_W] = fetch_pix_s[l*DATA_W +: DATA_W];
      end
      if (in_fire_s && fetch_keep_s[l] && (fetch_y_s == wr_y_r) && (fetch_x_s == wr_x_r))
        fetch_pix_s[l*DATA_W +: DATA_W] = in_pixels[l*DATA_W +: DATA_W];
      else
        fetch_pix_s[l*DATA_W +: DATA_W] = fetch_pix_s[l*DATA_W +: DATA_W];
    end
  end

  assign fetch_last_s = (fetch_y_s == LAST_Y) && ((fetch_x_s + STEP_X) >= LIM_X);

  // Pixel array write; lanes past the row end are dropped
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      for (int l = 0; l < PIX_PER_CLK; l++) begin
        for (int x = 0; x < OUT_W; x++) begin
          if ((wr_x_r + XW'(l)) == XW'(x)) mem_r[wr_y_r][x] <= in_pixels[l*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered drain beat, loaded ahead of each handshake so a stall holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_r  <= '0;
      keep_r <= '0;
      last_r <= 1'b0;
    end else if ((in_fire_s && wr_last_s) || (out_fire_s && !rd_last_s)) begin
      pix_r  <= fetch_pix_s;
      keep_r <= fetch_keep_s;
      last_r <= fetch_last_s;
    end else if (out_fire_s) begin
      pix_r  <= '0;
      keep_r <= '0;
      last_r <= 1'b0;
    end
  end

`ifdef TILE_STORE_STALL_CNT_EN
  // Stalled drain cycle counter, restarted as each tile begins draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (in_fire_s && wr_last_s) begin
      stall_cnt <= 16'h0000;
    end else if ((state_r == DRAIN) && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_tile_store2d_vec.sv
// Scoreboard bench for tile_store2d_vec: expected drain beats are queued as input beats are accepted.
module tb_tile_store2d_vec;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 30;
  localparam int OUT_H  = 30;
  localparam int PIX    = 4;
  localparam int BPR    = 8;
  localparam int BEATS  = 240;

  typedef struct packed {
    logic [31:0] pix;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pixels;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pixels;
  logic [3:0]  out_keep;
  logic        out_last;
`ifdef TILE_STORE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tile_store2d_vec #(.DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_H(OUT_H), .PIX_PER_CLK(PIX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixels(in_pixels),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixels(out_pixels),
    .out_keep(out_keep),
`ifdef TILE_STORE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_last(out_last)
  );

  // Drives nbeats input beats and queues the drain beat each one should produce.
  task automatic fill_tile(input int nbeats, input bit mark, output bit timeout, output int early_ov);
    int b = 0;
    int cyc = 0;
    beat_t e;
    early_ov = 0;
    while (b < nbeats && cyc < 4*BEATS) begin
      in_valid  = 1'b1;
      in_pixels = (mark && b == 3*BPR + BPR - 1) ? 32'hDDCCBBAA : $urandom;
      @(negedge clk);
      if (out_valid) early_ov++;
      if (in_ready) begin
        e.pix  = in_pixels;
        e.last = (b == BEATS - 1);
        for (int l = 0; l < PIX; l++) begin
          e.keep[l] = (((b % BPR) * PIX + l) < OUT_W);
          if (!e.keep[l]) e.pix[l*DATA_W +: DATA_W] = 8'h00;
        end
        exp_q.push_back(e);
        b++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    timeout = (b < nbeats);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    checks++;
    if ({out_pixels, out_keep, out_last} !== 37'h0) begin
      errors++; $display("FAIL reset_data: pix=%h keep=%b last=%b, want zeros", out_pixels, out_keep, out_last);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    bit to; int ov; int n = 0; int cyc = 0; beat_t got, e;
    fill_tile(BEATS, 1'b1, to, ov);
    checks++;
    if (to || ov != 0) begin
      errors++; $display("FAIL fd_fill: timeout=%0d early_out_valid=%0d, want 0/0", to, ov);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fd_latency: in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
    end
    while (n < BEATS && cyc < 4*BEATS) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_pixels, out_keep, out_last};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL fd_beat%0d: got %h, want %h", n, got, e);
        end
        if (n == 3*BPR + BPR - 1) begin
          checks++;
          if (out_keep !== 4'b0011 || out_pixels !== 32'h0000BBAA) begin
            errors++; $display("FAIL fd_row_tail: keep=%b pix=%h, want 0011/0000bbaa", out_keep, out_pixels);
          end
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (cyc != BEATS) begin
      errors++; $display("FAIL fd_drain_cycles: got %0d, want %0d", cyc, BEATS);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_pixels, out_keep, out_last} !== 37'h0) begin
      errors++; $display("FAIL fd_back_to_fill: in_ready=%b out_valid=%b pix=%h, want 1/0/0", in_ready, out_valid, out_pixels);
    end
  endtask

  task automatic test_in_during_drain();
    bit to; int ov; int n = 0; int cyc = 0; int busy = 0; beat_t got, e;
    fill_tile(BEATS, 1'b0, to, ov);
    checks++;
    if (to) begin
      errors++; $display("FAIL idd_fill: timeout=%0d, want 0", to);
    end
    while (n < BEATS && cyc < 4*BEATS) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pixels = $urandom;
      @(negedge clk);
      if (in_ready) busy++;
      if (out_valid && out_ready) begin
        got = {out_pixels, out_keep, out_last};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL idd_beat%0d: got %h, want %h", n, got, e);
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (busy != 0 || cyc != BEATS) begin
      errors++; $display("FAIL idd_ready_low: in_ready_cycles=%0d drain_cycles=%0d, want 0/%0d", busy, cyc, BEATS);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idd_reaccept: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_stall();
    bit to; int ov; int n = 0; int cyc = 0; bit stalled = 1'b0; beat_t got, e, held;
    fill_tile(BEATS, 1'b0, to, ov);
    checks++;
    if (to) begin
      errors++; $display("FAIL st_fill: timeout=%0d, want 0", to);
    end
    while (n < BEATS && cyc < 4*BEATS) begin
      out_ready = (cyc % 2 == 0);
      @(negedge clk);
      got = {out_pixels, out_keep, out_last};
      if (stalled) begin
        checks++;
        if (got !== held) begin
          errors++; $display("FAIL st_hold%0d: got %h, want %h", n, got, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = got;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL st_beat%0d: got %h, want %h", n, got, e);
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (cyc != 2*BEATS - 1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL st_cycles: got %0d out_valid=%b, want %0d/0", cyc, out_valid, 2*BEATS - 1);
    end
`ifdef TILE_STORE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd239) begin
      errors++; $display("FAIL st_stall_cnt: got %0d, want 239", stall_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'd239) begin
      errors++; $display("FAIL st_stall_hold: got %0d, want 239", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit to; int ov; int n = 0; int cyc = 0; beat_t got, e;
    fill_tile(BEATS, 1'b0, to, ov);
    out_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_pixels, out_keep, out_last} !== 37'h0) begin
      errors++; $display("FAIL rm_drain_async: in_ready=%b out_valid=%b pix=%h keep=%b, want 1/0/0/0", in_ready, out_valid, out_pixels, out_keep);
    end
    exp_q.delete();
    out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fill_tile(100, 1'b0, to, ov);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL rm_fill_async: in_ready=%b out_valid=%b last=%b, want 1/0/0", in_ready, out_valid, out_last);
    end
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fill_tile(BEATS, 1'b0, to, ov);
    checks++;
    if (to || out_valid !== 1'b1) begin
      errors++; $display("FAIL rm_refill: timeout=%0d out_valid=%b, want 0/1", to, out_valid);
    end
    while (n < BEATS && cyc < 4*BEATS) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_pixels, out_keep, out_last};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL rm_beat%0d: got %h, want %h", n, got, e);
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (cyc != BEATS || out_valid !== 1'b0) begin
      errors++; $display("FAIL rm_drain_cycles: got %0d out_valid=%b, want %0d/0", cyc, out_valid, BEATS);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pixels = 32'h0;
    test_reset();
    test_fill_drain();
    test_in_during_drain();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_store2d_vec.md
TILE_STORE2D_VEC -- requirements
Module: tile_store2d_vec

Interface
REQ-001 Parameter DATA_W, 8, bits per pixel.
REQ-002 Parameter OUT_W, 30, result-tile width in pixels (window-sweep output width).
REQ-003 Parameter OUT_H, 30, result-tile height in rows.
REQ-004 Parameter PIX_PER_CLK, 4, pixels per beat on both input and output.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  result vector valid.
REQ-008 in_ready  output  1  block accepts a result vector.
REQ-009 in_pixels  input  DATA_W*PIX_PER_CLK  lane l at [l*DATA_W +: DATA_W], lane 0 = leftmost pixel.
REQ-010 out_valid  output  1  drain vector valid.
REQ-011 out_ready  input  1  downstream accepts drain vector.
REQ-012 out_pixels  output  DATA_W*PIX_PER_CLK  same lane packing as in_pixels.
REQ-013 out_keep  output  PIX_PER_CLK  per-lane pixel-present mask.
REQ-014 out_last  output  1  final beat of the tile.

Function
REQ-015 BPR = ceil(OUT_W/PIX_PER_CLK) beats per row; a tile is BPR*OUT_H beats, row-major, each row starting at lane 0 of a new beat.
REQ-016 Storage: OUT_H x OUT_W pixel array; write x pointer steps by PIX_PER_CLK, y pointer by 1.
REQ-017 States: FILL, DRAIN; reset state FILL.
REQ-018 in_ready = 1 in FILL, 0 in DRAIN (combinational from state).
REQ-019 Input handshake (in_valid && in_ready) writes lane l to column wr_x+l of row wr_y only when wr_x+l < OUT_W; other lanes discarded.
REQ-020 After a handshake at wr_x+PIX_PER_CLK >= OUT_W: wr_x -> 0, wr_y += 1; otherwise wr_x += PIX_PER_CLK.
REQ-021 Handshake of the last beat (final row, final beat) -> DRAIN next cycle; write pointers -> 0.
REQ-022 out_valid = 1 exactly in DRAIN; first out_valid in the cycle after the last input handshake (latency 1).
REQ-023 out_pixels lane l = stored pixel (rd_y, rd_x+l) when rd_x+l < OUT_W, else 0; out_keep[l] = (rd_x+l < OUT_W); valid only while out_valid=1, all zero otherwise.
REQ-024 out_last = 1 when out_valid and rd_y = OUT_H-1 and rd_x+PIX_PER_CLK >= OUT_W.
REQ-025 Output handshake advances rd pointers by the REQ-020 rule; out_valid && !out_ready holds out_pixels/out_keep/out_last stable.
REQ-026 Handshake with out_last -> FILL next cycle; read pointers -> 0; in_ready rises that cycle.
REQ-027 in_valid in DRAIN has no effect; input and output are never accepted in the same cycle.
REQ-028 Stored contents of a tile are not cleared between tiles; every in-range location is rewritten each FILL.

Reset
REQ-029 rst_n low immediately forces state FILL, all pointers 0, in_ready 1, out_valid 0, out_keep 0, out_last 0, out_pixels 0.
REQ-030 Reset mid-FILL or mid-DRAIN aborts the tile; the next accepted beat is row 0, beat 0; memory contents are not reset.

Configuration
REQ-031 Macro TILE_STORE_STALL_CNT_EN defined: extra output stall_cnt [15:0] counts cycles with out_valid && !out_ready, saturates at 16'hFFFF, clears to 0 on the FILL->DRAIN transition and on reset, and holds after the tile drains.
REQ-032 Macro undefined: stall_cnt port and its counter are absent; all other behaviour is identical.

Verification (defaults: BPR=8, 240 beats/tile)
REQ-033 Reset, then 240 in beats with in_valid held and out_ready=1 -> in_ready=0 and out_valid=1 exactly 1 cycle after beat 240; 240 out beats; out_last only on beat 240; data matches input pixel-for-pixel.
REQ-034 Row beat 8 with in_pixels lanes {AA,BB,CC,DD} (lane 0 first) -> out beat 8 of that row has out_keep=4'b0011, lanes 0-1 = AA,BB, lanes 2-3 = 0.
REQ-035 out_ready toggled 1/0 each cycle during DRAIN -> no beat lost or duplicated; outputs stable while stalled; with TILE_STORE_STALL_CNT_EN, stall_cnt = 239 after drain.
REQ-036 in_valid=1 throughout DRAIN with changing data -> stored tile unaffected; second tile accepted only after the out_last handshake.
REQ-037 rst_n pulsed low after 100 in beats -> outputs at reset values asynchronously; a full 240-beat tile then drains correctly with out_last on beat 240.
